uart_rx_frame_ctrl: RTL

//  Frame controller behind the UART receiver: consumes (rcv, data) byte strobes and parses frames

---
 rtl/uart_rx_frame_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: parses SYNC/ADDR/LEN/PAYLOAD/CHK, buffers payload, commits to reg bank.
// Latency: first write request the cycle after CHK is accepted; back-to-back writes while wr_ready holds.
// Backpressure: wr_ready stalls COMMIT with address/data held; bytes arriving then are dropped (overrun). Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rcv,
    input  logic [7:0] data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_COMMIT
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] base, base_nxt;
    logic [7:0] len, len_nxt;
    logic [7:0] sum, sum_nxt;
    logic [7:0] idx, idx_nxt;
    logic       wr_valid_nxt;
    logic [7:0] wr_addr_nxt;
    logic [7:0] wr_data_nxt;
    logic       frame_ok_nxt;
    logic       frame_err_nxt;
    logic [1:0] err_code_nxt;
    logic       overrun_nxt;
    logic       busy_nxt;
    logic       buf_we;
    logic       timed;
    logic       tmo_expire;

    logic [7:0] pay_buf [MAX_LEN];

    assign timed = (state == S_ADDR) || (state == S_LEN) ||
                   (state == S_PAYLOAD) || (state == S_CHK);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (rcv) begin
            tmo_cnt <= TW'(TIMEOUT_CYC);
        end else if (timed && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // Expire on the edge that would take the count to zero, so the error
    // lands TIMEOUT_CYC edges after the edge that sampled the last byte.
    assign tmo_expire = timed && !rcv && (tmo_cnt <= TW'(1));
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        len_nxt       = len;
        sum_nxt       = sum;
        idx_nxt       = idx;
        wr_valid_nxt  = wr_valid;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        frame_ok_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        err_code_nxt  = err_code;
        overrun_nxt   = 1'b0;
        buf_we        = 1'b0;

        case (state)
            S_HUNT: begin
                if (rcv && (data == SYNC_BYTE)) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rcv) begin
                    base_nxt  = data;
                    sum_nxt   = data;
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (rcv) begin
                    if ((data == 8'd0) || (data > MAX_LEN_B)) begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'd1;
                        state_nxt     = S_HUNT;
                    end else begin
                        len_nxt   = data;
                        sum_nxt   = sum + data;
                        idx_nxt   = 8'd0;
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rcv) begin
                    buf_we  = 1'b1;
                    sum_nxt = sum + data;
                    idx_nxt = idx + 8'd1;
                    if (idx == (len - 8'd1)) begin
                        state_nxt = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rcv) begin
                    if (data == sum) begin
                        state_nxt    = S_COMMIT;
                        idx_nxt      = 8'd0;
                        wr_valid_nxt = 1'b1;
                        wr_addr_nxt  = base;
                        wr_data_nxt  = pay_buf[0];
                    end else begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'd2;
                        state_nxt     = S_HUNT;
                    end
                end
            end
            S_COMMIT: begin
                // Incoming bytes cannot be parsed while the buffer drains.
                overrun_nxt = rcv;
                if (wr_valid && wr_ready) begin
                    if (idx == (len - 8'd1)) begin
                        wr_valid_nxt = 1'b0;
                        frame_ok_nxt = 1'b1;
                        state_nxt    = S_HUNT;
                    end else begin
                        idx_nxt     = idx + 8'd1;
                        wr_addr_nxt = base + idx + 8'd1;
                        wr_data_nxt = pay_buf[idx_nxt[IW-1:0]];
                    end
                end
            end
            default: begin
                state_nxt    = S_HUNT;
                wr_valid_nxt = 1'b0;
            end
        endcase

        if (tmo_expire) begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'd3;
            state_nxt     = S_HUNT;
        end

        busy_nxt = (state_nxt != S_HUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_HUNT;
            base      <= 8'd0;
            len       <= 8'd0;
            sum       <= 8'd0;
            idx       <= 8'd0;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            len       <= len_nxt;
            sum       <= sum_nxt;
            idx       <= idx_nxt;
            wr_valid  <= wr_valid_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            frame_ok  <= frame_ok_nxt;
            frame_err <= frame_err_nxt;
            err_code  <= err_code_nxt;
            overrun   <= overrun_nxt;
            busy      <= busy_nxt;
        end
    end

    // Payload storage carries no reset; it is only read after being filled.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pay_buf[idx[IW-1:0]] <= data;
        end
    end

endmodule
